// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               FSM state encoding, NOP instruction word, instruction width
//               and the PC increment helper.
//               With FETCH_MISALIGN_TRAP_EN defined, the TRAP state is part
//               of the encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam int INST_WIDTH = 32;

  // ADDI x0, x0, 0: held in the instruction register whenever no real
  // instruction has been fetched yet.
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_ACK = 2'd1,
    VALID    = 2'd2,
    TRAP     = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_ACK = 2'd1,
    VALID    = 2'd2
  } fetch_state_e;
`endif

  // Sequential word address. The addition wraps modulo 2^32, so 0xFFFF_FFFC
  // is followed by 0x0000_0000 with no flag.
  function automatic logic [31:0] pc_next(input logic [31:0] cur_pc);
    return cur_pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Fetch-address register. It loads a redirect target or steps
//               to the next word. Redirect has priority over the sequential
//               step.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic        clk,
  input  logic        rstN,
  input  logic        advance,
  input  logic        load,
  input  logic [31:0] target,
  output logic [31:0] fetch_pc
);

  logic [31:0] fetch_pc_q;
  logic [31:0] fetch_pc_d;

  // Select the next fetch address. A redirect overrides the sequential step.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (load) begin
      fetch_pc_d = target;
    end else if (advance) begin
      fetch_pc_d = pc_next(fetch_pc_q);
    end
  end

  // Fetch-address register with asynchronous reset to the boot address.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign fetch_pc = fetch_pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Single-outstanding-request instruction fetch stage.
//               The cycle sequence is FETCH -> WAIT_ACK -> VALID.
//               Redirects are honoured in every state. A late acknowledge
//               for an abandoned request is dropped.
//               Optional macro FETCH_MISALIGN_TRAP_EN:
//                 - Defined: a misaligned redirect target sets a sticky trap.
//                   Fetching then stops until reset.
//                 - Undefined: redirect targets are forced to word alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirectTarget,
  output logic                  imemReq,
  output logic [31:0]           imemAddr,
  input  logic                  imemAck,
  input  logic [INST_WIDTH-1:0] imemData,
  output logic                  instValid,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [31:0]           pc,
  output logic [31:0]           pcPlus4,
  output logic                  misalignTrap
);

  fetch_state_e          state_q, state_d;
  logic [INST_WIDTH-1:0] instruction_q, instruction_d;
  logic [31:0]           pc_q, pc_d;
  logic                  inst_valid_q, inst_valid_d;
  logic                  drop_q, drop_d;
  logic                  trap_q, trap_d;

  logic                  pc_advance;
  logic                  pc_load;
  logic [31:0]           fetch_pc;
  logic [31:0]           redirect_pc;
  logic                  in_trap;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic                  redirect_misaligned;
  assign redirect_pc         = redirectTarget;
  assign redirect_misaligned = |redirectTarget[1:0];
  assign in_trap             = (state_q == TRAP);
`else
  // Low target bits are ignored so the fetch address is always word-aligned.
  logic                  unused_target_bits;
  assign redirect_pc         = {redirectTarget[31:2], 2'b00};
  assign unused_target_bits  = ^redirectTarget[1:0];
  assign in_trap             = 1'b0;
`endif

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_fetch_pc_reg (
    .clk      (clk),
    .rstN     (rstN),
    .advance  (pc_advance),
    .load     (pc_load),
    .target   (redirect_pc),
    .fetch_pc (fetch_pc)
  );

  // Next-state and datapath selection. A redirect beats stall and any
  // acknowledge that arrives in the same cycle.
  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;
    drop_d        = drop_q;
    trap_d        = trap_q;
    pc_advance    = 1'b0;
    pc_load       = 1'b0;

    // The acknowledge of an abandoned request consumes the drop flag.
    if (drop_q && imemAck) begin
      drop_d = 1'b0;
    end

    if (redirect && !in_trap) begin
      inst_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_misaligned) begin
        trap_d  = 1'b1;
        state_d = TRAP;
      end else
`endif
      begin
        pc_load = 1'b1;
        state_d = FETCH;
        // The request in flight is abandoned. Its acknowledge must be dropped
        // unless that acknowledge arrives in this same cycle.
        if (state_q == WAIT_ACK) begin
          drop_d = !(imemAck && !drop_q);
        end
      end
    end else begin
      case (state_q)
        FETCH: begin
          state_d = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (imemAck && !drop_q) begin
            instruction_d = imemData;
            pc_d          = fetch_pc;
            inst_valid_d  = 1'b1;
            state_d       = VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            pc_advance   = 1'b1;
            inst_valid_d = 1'b0;
            state_d      = FETCH;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP: begin
          state_d = TRAP;
        end
`endif
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // FSM and output registers. Reset abandons any request that is in flight.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= FETCH;
      instruction_q <= NOP_INST;
      pc_q          <= RESET_PC;
      inst_valid_q  <= 1'b0;
      drop_q        <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
      drop_q        <= drop_d;
      trap_q        <= trap_d;
    end
  end

  // The request is decoded from the state. It is masked while reset is held,
  // so the first cycle after release already issues RESET_PC.
  assign imemReq      = rstN && ((state_q == FETCH) || (state_q == WAIT_ACK));
  assign imemAddr     = fetch_pc;
  assign instValid    = inst_valid_q;
  assign instruction  = instruction_q;
  assign pc           = pc_q;
  assign pcPlus4      = pc_next(pc_q);
  assign misalignTrap = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
//               The memory model answers one cycle after a request with
//               the word 0x00500093 + address.
//               FETCH_MISALIGN_TRAP_EN selects the expected behaviour for a
//               misaligned redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        rstN;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instValid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        misalignTrap;

  int total;
  int bad;
  bit auto_mem;
  bit pending;

  fetch_stage #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rstN           (rstN),
    .stall          (stall),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemAck        (imemAck),
    .imemData       (imemData),
    .instValid      (instValid),
    .instruction    (instruction),
    .pc             (pc),
    .pcPlus4        (pcPlus4),
    .misalignTrap   (misalignTrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: a request seen in one cycle is acknowledged in the next cycle.
  task automatic mem_tick();
    if (auto_mem) begin
      if (imemReq && pending) begin
        imemAck  = 1'b1;
        imemData = 32'h0050_0093 + imemAddr;
        pending  = 1'b0;
      end else begin
        imemAck  = 1'b0;
        pending  = imemReq;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mem_tick();
  endtask

  initial begin
    total = 0; bad = 0;
    auto_mem = 1'b1; pending = 1'b0;
    rstN = 1'b0; stall = 1'b0; redirect = 1'b0; redirectTarget = 32'h0;
    imemAck = 1'b0; imemData = 32'h0;

    // Reset state
    step(); step();
    chk("rst_req",   {31'b0, imemReq},      32'h0);
    chk("rst_valid", {31'b0, instValid},    32'h0);
    chk("rst_pc",    pc,                    32'h0);
    chk("rst_inst",  instruction,           32'h0000_0013);
    chk("rst_trap",  {31'b0, misalignTrap}, 32'h0);
    chk("rst_p4",    pcPlus4,               32'h4);

    // Sequential fetch: 0, 4, 8; one instruction every third cycle
    rstN = 1'b1; #1; mem_tick();
    chk("f0_req",  {31'b0, imemReq},   32'h1);
    chk("f0_addr", imemAddr,           32'h0);
    step();
    chk("w0_req",  {31'b0, imemReq},   32'h1);
    chk("w0_addr", imemAddr,           32'h0);
    step();
    chk("v0_valid", {31'b0, instValid}, 32'h1);
    chk("v0_inst",  instruction,        32'h0050_0093);
    chk("v0_pc",    pc,                 32'h0);
    chk("v0_req",   {31'b0, imemReq},   32'h0);
    step();
    chk("f1_addr",  imemAddr,           32'h4);
    chk("f1_valid", {31'b0, instValid}, 32'h0);
    step(); step();
    chk("v1_inst",  instruction,        32'h0050_0097);
    chk("v1_pc",    pc,                 32'h4);

    // Stall holds the instruction for 4 cycles
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("st_valid", {31'b0, instValid}, 32'h1);
      chk("st_pc",    pc,                 32'h4);
      chk("st_inst",  instruction,        32'h0050_0097);
      chk("st_req",   {31'b0, imemReq},   32'h0);
    end
    stall = 1'b0;
    step();
    chk("st_next_addr", imemAddr, 32'h8);
    step(); step();
    chk("v2_pc",   pc,          32'h8);
    chk("v2_inst", instruction, 32'h0050_009B);

    // Redirect in WAIT_ACK followed by a stale acknowledge
    step();
    chk("f3_addr", imemAddr, 32'hC);
    auto_mem = 1'b0;
    step();
    chk("w3_req", {31'b0, imemReq}, 32'h1);
    redirect = 1'b1; redirectTarget = 32'h0000_0100;
    step();
    redirect = 1'b0;
    imemAck = 1'b1; imemData = 32'hDEAD_BEEF;
    chk("rd_addr",  imemAddr,           32'h100);
    chk("rd_valid", {31'b0, instValid}, 32'h0);
    step();
    imemAck = 1'b1; imemData = 32'h0050_0193;
    chk("rd_wait_valid", {31'b0, instValid}, 32'h0);
    chk("rd_wait_addr",  imemAddr,           32'h100);
    step();
    imemAck = 1'b0;
    chk("rd_v_valid", {31'b0, instValid}, 32'h1);
    chk("rd_v_pc",    pc,                 32'h100);
    chk("rd_v_inst",  instruction,        32'h0050_0193);

    // Redirect to the top word; the PC wraps to 0
    auto_mem = 1'b1; pending = 1'b0;
    redirect = 1'b1; redirectTarget = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wr_addr", imemAddr, 32'hFFFF_FFFC);
    step(); step();
    chk("wr_pc",   pc,          32'hFFFF_FFFC);
    chk("wr_p4",   pcPlus4,     32'h0);
    chk("wr_inst", instruction, 32'h0050_008F);
    step();
    chk("wr_next_addr", imemAddr, 32'h0);

    // Misaligned redirect
    auto_mem = 1'b0; imemAck = 1'b0;
    redirect = 1'b1; redirectTarget = 32'h0000_0102;
    step();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("ma_trap", {31'b0, misalignTrap}, 32'h1);
    chk("ma_req",  {31'b0, imemReq},      32'h0);
    step();
    chk("ma_trap_hold", {31'b0, misalignTrap}, 32'h1);
    chk("ma_req_hold",  {31'b0, imemReq},      32'h0);
`else
    chk("ma_addr", imemAddr,               32'h100);
    chk("ma_trap", {31'b0, misalignTrap},  32'h0);
    chk("ma_req",  {31'b0, imemReq},       32'h1);
    step();
    chk("ma_wait_req", {31'b0, imemReq}, 32'h1);
`endif

    // Reset pulse in WAIT_ACK (or in TRAP)
    rstN = 1'b0; #1;
    chk("ar_req",   {31'b0, imemReq},      32'h0);
    chk("ar_valid", {31'b0, instValid},    32'h0);
    chk("ar_pc",    pc,                    32'h0);
    chk("ar_inst",  instruction,           32'h0000_0013);
    chk("ar_addr",  imemAddr,              32'h0);
    chk("ar_trap",  {31'b0, misalignTrap}, 32'h0);
    auto_mem = 1'b1; pending = 1'b0;
    rstN = 1'b1; #1; mem_tick();
    chk("ar_first_req",  {31'b0, imemReq}, 32'h1);
    chk("ar_first_addr", imemAddr,         32'h0);
    step(); step();
    chk("ar_v_valid", {31'b0, instValid}, 32'h1);
    chk("ar_v_pc",    pc,                 32'h0);
    chk("ar_v_inst",  instruction,        32'h0050_0093);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset SHALL be this value.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rstN  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  downstream not ready; held instruction SHALL NOT advance while high.
REQ-005 redirect  input  1  branch/jump taken; one-cycle pulse.
REQ-006 redirectTarget  input  32  new PC accompanying redirect.
REQ-007 imemReq  output  1  instruction memory request.
REQ-008 imemAddr  output  32  request address (word-aligned).
REQ-009 imemAck  input  1  memory response valid, 1+ cycles after request.
REQ-010 imemData  input  32  instruction word, valid with imemAck.
REQ-011 instValid  output  1  instruction/pc outputs hold a live instruction.
REQ-012 instruction  output  32  fetched word; bits [31:7] feed the immediate extender.
REQ-013 pc, pcPlus4  output  32 each  address of held instruction and that address + 4.
REQ-014 misalignTrap  output  1  misaligned redirect flagged (see Configuration).

Function
REQ-015 FSM states SHALL be FETCH, WAIT_ACK, VALID (plus TRAP when configured).
REQ-016 FETCH: imemReq=1, imemAddr=fetchPc; next state WAIT_ACK unconditionally.
REQ-017 WAIT_ACK: imemReq=1, imemAddr stable; on imemAck latch imemData into instruction, pc<=fetchPc, go VALID.
REQ-018 VALID: instValid=1; if stall=0, fetchPc<=fetchPc+4 and go FETCH; if stall=1 hold all outputs unchanged.
REQ-019 Minimum issue interval SHALL be 3 cycles per instruction (FETCH, WAIT_ACK with same-cycle ack, VALID).
REQ-020 redirect in any state SHALL set fetchPc<=redirectTarget, clear instValid next cycle, go FETCH; redirect wins over stall and over a same-cycle imemAck.
REQ-021 An imemAck arriving in the cycle after a redirect from WAIT_ACK SHALL be discarded via a one-bit drop flag; the flag clears on that ack or reset.
REQ-022 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
REQ-023 pcPlus4 SHALL equal pc+4 combinationally.

Reset
REQ-024 During rstN=0: state=FETCH, fetchPc=RESET_PC, pc=RESET_PC, instruction=32'h0000_0013 (NOP), instValid=0, imemReq=0, misalignTrap=0, drop flag=0.
REQ-025 Reset mid-WAIT_ACK SHALL abandon the request; first post-reset cycle issues RESET_PC.

Configuration
REQ-026 Macro FETCH_MISALIGN_TRAP_EN defined: redirectTarget[1:0]!=0 SHALL assert misalignTrap (sticky), enter TRAP, hold imemReq=0 and instValid=0 until rstN.
REQ-027 Macro undefined: redirectTarget[1:0] SHALL be forced to 2'b00, misalignTrap tied 0, no TRAP state.

Structure
REQ-028 Shared package SHALL hold state encoding typedef, NOP constant 32'h0000_0013, and INST_WIDTH=32.
REQ-029 One sub-module fetch_pc_reg (fetchPc register with increment/redirect mux) is natural; FSM stays in fetch_stage.

Verification
REQ-030 Reset release, RESET_PC=0, ack 1 cycle after req, data 32'h00500093 -> imemAddr 0,4,8 on successive fetches; instValid every 3rd cycle; instruction=00500093 at pc=0.
REQ-031 stall=1 for 4 cycles in VALID -> instruction, pc, instValid constant; imemReq=0; next imemAddr=pc+4 after release.
REQ-032 redirect to 32'h0000_0100 in WAIT_ACK, stale ack next cycle with 32'hDEADBEEF -> stale word never appears; next valid pc=0x100.
REQ-033 redirect to 32'hFFFF_FFFC, no stall -> pc=FFFF_FFFC, pcPlus4=0, following fetch address 0.
REQ-034 redirect to 32'h0000_0102: with macro -> misalignTrap=1, imemReq=0 until reset; without -> fetch at 0x100.
REQ-035 rstN pulsed low during WAIT_ACK -> outputs at reset values immediately; first request at RESET_PC.
